// File: rtl/fle_cfg_pkg.sv
// Shared configuration layout for the fracturable logic element (FLE).
// Control fields sit directly above the 2^K-bit LUT memory.
package fle_cfg_pkg;

  localparam int unsigned K_DEFAULT     = 4;
  localparam int unsigned CTRL_BITS     = 4;
  localparam int unsigned FRAC_OFS      = 0;
  localparam int unsigned OUT0_REG_OFS  = 1;
  localparam int unsigned OUT1_REG_OFS  = 2;
  localparam int unsigned REGIN_SEL_OFS = 3;

  function automatic int unsigned cfg_bits(input int unsigned k);
    return (32'd1 << k) + CTRL_BITS;
  endfunction

  typedef struct packed {
    logic                         regin_sel;
    logic                         out1_reg;
    logic                         out0_reg;
    logic                         frac;
    logic [(1<<K_DEFAULT)-1:0]    mem;
  } fle_cfg_t;

endpackage

// File: rtl/fle_cfg_chain.sv
// Serial config chain: shadow shifter, shift counter, commit to active, ok/err pulses.
// FLE_CFG_PARITY_EN adds a trailing even-parity bit to the shadow (not copied to active).
module fle_cfg_chain
  import fle_cfg_pkg::*;
#(
  parameter int unsigned CFG_BITS = cfg_bits(K_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_head,
  input  logic                i_en,
  input  logic                i_commit,
  output logic [CFG_BITS-1:0] o_active,
  output logic                o_tail,
  output logic                o_ok,
  output logic                o_err
);

`ifdef FLE_CFG_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  localparam int unsigned SH_BITS = CFG_BITS + PAR_BITS;
  localparam int unsigned CNT_MAX = CFG_BITS + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_REQ = CNT_W'(SH_BITS);

  logic [SH_BITS-1:0]  r_shadow;
  logic [CNT_W-1:0]    r_cnt;
  logic [CFG_BITS-1:0] r_active;
  logic                r_tail;
  logic                r_ok;
  logic                r_err;
  logic                w_par_ok;
  logic                w_accept;

`ifdef FLE_CFG_PARITY_EN
  assign w_par_ok = ~(^r_shadow);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_accept = (r_cnt == CNT_REQ) && w_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_active <= '0;
      r_tail   <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_tail <= r_shadow[SH_BITS-1];
      r_ok   <= 1'b0;
      r_err  <= 1'b0;
      if (i_en) begin
        // A commit presented alongside a shift is dropped.
        r_shadow <= {r_shadow[SH_BITS-2:0], i_head};
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (i_commit) begin
        r_cnt <= '0;
        if (w_accept) begin
          r_active <= r_shadow[SH_BITS-1 -: CFG_BITS];
          r_ok     <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_active = r_active;
  assign o_tail   = r_tail;
  assign o_ok     = r_ok;
  assign o_err    = r_err;

endmodule

// File: rtl/fle_cfg_param.sv
// Fracturable K-input LUT logic element with two output flops and a serial config chain.
// Optional build macro: FLE_CFG_PARITY_EN (parity-protected chain, see fle_cfg_chain).
module fle_cfg_param
  import fle_cfg_pkg::*;
#(
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] fle_in,
  input  logic         fle_regin,
  input  logic         fle_sc_in,
  input  logic         Test_en,
  input  logic         ccff_head,
  input  logic         cfg_en,
  input  logic         cfg_commit,
  output logic [1:0]   fle_out,
  output logic         fle_regout,
  output logic         fle_sc_out,
  output logic         ccff_tail,
  output logic         cfg_ok,
  output logic         cfg_err
);

  localparam int unsigned LUT_BITS = 1 << K;
  localparam int unsigned CFG_BITS = cfg_bits(K);

  logic [CFG_BITS-1:0] w_active;
  logic [LUT_BITS-1:0] w_mem;
  logic                w_frac;
  logic                w_out0_reg;
  logic                w_out1_reg;
  logic                w_regin_sel;
  logic [K-1:0]        w_idx0;
  logic [K-1:0]        w_idx1;
  logic                w_lut0;
  logic                w_lut1;
  logic                w_d0;
  logic                w_d1;
  logic                r_ff0;
  logic                r_ff1;

  fle_cfg_chain #(
    .CFG_BITS(CFG_BITS)
  ) u_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_head   (ccff_head),
    .i_en     (cfg_en),
    .i_commit (cfg_commit),
    .o_active (w_active),
    .o_tail   (ccff_tail),
    .o_ok     (cfg_ok),
    .o_err    (cfg_err)
  );

  assign w_mem       = w_active[LUT_BITS-1:0];
  assign w_frac      = w_active[LUT_BITS + FRAC_OFS];
  assign w_out0_reg  = w_active[LUT_BITS + OUT0_REG_OFS];
  assign w_out1_reg  = w_active[LUT_BITS + OUT1_REG_OFS];
  assign w_regin_sel = w_active[LUT_BITS + REGIN_SEL_OFS];

  // Fractured mode splits the memory into two (K-1)-input halves; the top input is unused.
  always_comb begin
    w_idx0 = fle_in;
    w_idx1 = fle_in;
    if (w_frac) begin
      w_idx0 = {1'b0, fle_in[K-2:0]};
      w_idx1 = {1'b1, fle_in[K-2:0]};
    end
    w_lut0 = w_mem[w_idx0];
    w_lut1 = w_mem[w_idx1];
  end

  always_comb begin
    if (Test_en) begin
      w_d0 = fle_sc_in;
      w_d1 = r_ff0;
    end else begin
      w_d0 = w_regin_sel ? fle_regin : w_lut0;
      w_d1 = w_lut1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff0 <= 1'b0;
      r_ff1 <= 1'b0;
    end else begin
      r_ff0 <= w_d0;
      r_ff1 <= w_d1;
    end
  end

  assign fle_out[0] = w_out0_reg ? r_ff0 : w_lut0;
  assign fle_out[1] = w_out1_reg ? r_ff1 : w_lut1;
  assign fle_regout = r_ff1;
  assign fle_sc_out = r_ff1;

endmodule
